// File: rtl/scie_fir_pkg.sv
// Shared constants for the SCIE FIR accelerator: opcodes and default sizing.
package scie_fir_pkg;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_NTAPS = 5;

  localparam logic [6:0] OPC_COEF_WR = 7'h0B;
  localparam logic [6:0] OPC_PUSH    = 7'h2B;
  localparam logic [6:0] OPC_READ    = 7'h5B;
endpackage

// File: rtl/fir_tap_mac.sv
// Coefficient and sample registers plus the stage-1 product registers.
// Products are refreshed every cycle from the current c/x, so updates show one cycle later.
module fir_tap_mac
  import scie_fir_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NTAPS = DEF_NTAPS,
  parameter int IDXW  = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        coef_wr_i,
  input  logic [IDXW-1:0]             coef_idx_i,
  input  logic [XLEN-1:0]             coef_dat_i,
  input  logic                        push_i,
  input  logic [XLEN-1:0]             sample_i,
  output logic [NTAPS-1:0][XLEN-1:0]  prod_o
);

  logic [NTAPS-1:0][XLEN-1:0] c_q, c_d;
  logic [NTAPS-1:0][XLEN-1:0] x_q, x_d;
  logic [NTAPS-1:0][XLEN-1:0] p_q, p_d;

  always_comb begin
    c_d = c_q;
    x_d = x_q;
    p_d = p_q;
    if (coef_wr_i) begin
      c_d[coef_idx_i] = coef_dat_i;
    end
    if (push_i) begin
      x_d[0] = sample_i;
      for (int i = 1; i < NTAPS; i++) begin
        x_d[i] = x_q[i-1];
      end
    end
    // Low XLEN bits of the unsigned product; the context width truncates.
    for (int i = 0; i < NTAPS; i++) begin
      p_d[i] = c_q[i] * x_q[i];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      c_q <= '0;
      x_q <= '0;
      p_q <= '0;
    end else begin
      c_q <= c_d;
      x_q <= x_d;
      p_q <= p_d;
    end
  end

  assign prod_o = p_q;

endmodule

// File: rtl/scie_fir_pipelined.sv
// SCIE custom-instruction FIR: opcode decode, tap/MAC array, and the summing stage into io_rd.
// One instruction per cycle, no backpressure; READ sees PUSH/COEF_WR only two or more cycles later.
module scie_fir_pipelined
  import scie_fir_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NTAPS = DEF_NTAPS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_valid,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic [XLEN-1:0] io_rd
);

  localparam int IDXW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  logic [6:0]                 opcode;
  logic                       idx_ok;
  logic                       coef_wr;
  logic                       push;
  logic                       read;
  logic [NTAPS-1:0][XLEN-1:0] prod;
  logic [XLEN-1:0]            sum;
  logic [XLEN-1:0]            rd_q, rd_d;
  logic                       unused_insn_hi;

  assign opcode         = io_insn[6:0];
  assign unused_insn_hi = ^io_insn[31:7];

  // Out-of-range coefficient indices are dropped here so the tap array never sees them.
  assign idx_ok  = (io_rs2 < XLEN'(NTAPS));
  assign coef_wr = io_valid && (opcode == OPC_COEF_WR) && idx_ok;
  assign push    = io_valid && (opcode == OPC_PUSH);
  assign read    = io_valid && (opcode == OPC_READ);

  fir_tap_mac #(
    .XLEN  (XLEN),
    .NTAPS (NTAPS),
    .IDXW  (IDXW)
  ) u_tap_mac (
    .clock_i    (clock),
    .reset_i    (reset),
    .coef_wr_i  (coef_wr),
    .coef_idx_i (io_rs2[IDXW-1:0]),
    .coef_dat_i (io_rs1),
    .push_i     (push),
    .sample_i   (io_rs1),
    .prod_o     (prod)
  );

  always_comb begin
    sum = '0;
    for (int i = 0; i < NTAPS; i++) begin
      sum = sum + prod[i];
    end
  end

  always_comb begin
    rd_d = rd_q;
    if (read) begin
      rd_d = sum;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign io_rd = rd_q;

endmodule

// File: tb/tb_scie_fir_pipelined.sv
// Directed bench for scie_fir_pipelined: a cycle-level reference model pushes the expected
// io_rd for every step into a scoreboard queue, popped and checked one tick after the edge.
module tb_scie_fir_pipelined;
  import scie_fir_pkg::*;

  localparam int XLEN  = 32;
  localparam int NTAPS = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            io_valid;
  logic [31:0]     io_insn;
  logic [XLEN-1:0] io_rs1;
  logic [XLEN-1:0] io_rs2;
  logic [XLEN-1:0] io_rd;

  scie_fir_pipelined #(.XLEN(XLEN), .NTAPS(NTAPS)) dut (
    .clock    (clock),
    .reset    (reset),
    .io_valid (io_valid),
    .io_insn  (io_insn),
    .io_rs1   (io_rs1),
    .io_rs2   (io_rs2),
    .io_rd    (io_rd)
  );

  always #5 clock = ~clock;

  logic [XLEN-1:0] mc [NTAPS];
  logic [XLEN-1:0] mx [NTAPS];
  logic [XLEN-1:0] mp [NTAPS];
  logic [XLEN-1:0] mrd;

  logic [XLEN-1:0] sb_q [$];
  string           tag_q [$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic model_clear();
    for (int i = 0; i < NTAPS; i++) begin
      mc[i] = '0;
      mx[i] = '0;
      mp[i] = '0;
    end
    mrd = '0;
  endtask

  task automatic check_pop();
    logic [XLEN-1:0] exp_v;
    string           tag;
    exp_v = sb_q.pop_front();
    tag   = tag_q.pop_front();
    n_assert++;
    assert (io_rd === exp_v) else begin
      n_fail++;
      $error("FAIL %s: io_rd observed=%0d expected=%0d", tag, io_rd, exp_v);
    end
  endtask

  // Apply one instruction for one cycle and advance the model across the same edge.
  task automatic step(input logic v, input logic [6:0] opc,
                      input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                      input string tag);
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] np [NTAPS];
    @(negedge clock);
    io_valid = v;
    io_insn  = {$urandom_range(0, 32'h1FF_FFFF) & 32'h1FF_FFFF, 7'h00} | {25'h0, opc};
    io_rs1   = rs1;
    io_rs2   = rs2;
    sum = '0;
    for (int i = 0; i < NTAPS; i++) begin
      sum   = sum + mp[i];
      np[i] = mc[i] * mx[i];
    end
    if (v && opc == OPC_READ) mrd = sum;
    if (v && opc == OPC_COEF_WR && rs2 < NTAPS) mc[rs2] = rs1;
    if (v && opc == OPC_PUSH) begin
      for (int i = NTAPS - 1; i > 0; i--) mx[i] = mx[i-1];
      mx[0] = rs1;
    end
    for (int i = 0; i < NTAPS; i++) mp[i] = np[i];
    sb_q.push_back(mrd);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    check_pop();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset    = 1'b1;
    io_valid = 1'b0;
    model_clear();
    sb_q.push_back('0);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    check_pop();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic push_read(input logic [XLEN-1:0] s, input string tag);
    step(1'b1, OPC_PUSH, s, 32'd0, {tag, "_push"});
    step(1'b0, OPC_PUSH, 32'd0, 32'd0, {tag, "_idle"});
    step(1'b1, OPC_READ, 32'd0, 32'd0, tag);
  endtask

  initial begin
    reset    = 1'b1;
    io_valid = 1'b0;
    io_insn  = '0;
    io_rs1   = '0;
    io_rs2   = '0;
    model_clear();
    repeat (2) @(posedge clock);
    do_reset("reset_state");

    step(1'b1, OPC_COEF_WR, 32'd6,  32'd0, "coef0");
    step(1'b1, OPC_COEF_WR, 32'd80, 32'd1, "coef1");
    step(1'b1, OPC_COEF_WR, 32'd79, 32'd2, "coef2");
    step(1'b1, OPC_COEF_WR, 32'd8,  32'd3, "coef3");
    step(1'b1, OPC_COEF_WR, 32'd24, 32'd4, "coef4");
    push_read(32'd48, "read_288");
    push_read(32'd62, "read_4212");
    push_read(32'd75, "read_9202");
    push_read(32'd24, "read_11426");
    push_read(32'd42, "read_full_9745");
    push_read(32'd0,  "read_oldest_dropped");

    step(1'b1, OPC_COEF_WR, 32'd1000, 32'd7, "coef_oob");
    step(1'b0, OPC_READ, 32'd0, 32'd0, "oob_idle");
    step(1'b1, OPC_READ, 32'd0, 32'd0, "oob_reread");
    step(1'b1, OPC_COEF_WR, 32'd1000, 32'd5, "coef_oob5");
    step(1'b0, OPC_READ, 32'd0, 32'd0, "oob5_idle");
    step(1'b1, OPC_READ, 32'd0, 32'd0, "oob5_reread");

    step(1'b0, OPC_READ, 32'd0, 32'd0, "hold_invalid_read");
    step(1'b1, 7'h7B, 32'd123, 32'd1, "unknown_opc");
    step(1'b0, OPC_READ, 32'd0, 32'd0, "unknown_idle");
    step(1'b1, OPC_READ, 32'd0, 32'd0, "unknown_reread");

    // Back-to-back PUSH then READ sees the older products; the next READ sees the new ones.
    step(1'b1, OPC_PUSH, 32'd9, 32'd0, "hazard_push");
    step(1'b1, OPC_READ, 32'd0, 32'd0, "hazard_read_stale");
    step(1'b1, OPC_READ, 32'd0, 32'd0, "hazard_read_fresh");

    do_reset("reset_mid");
    push_read(32'd5, "read_after_reset");

    step(1'b1, OPC_COEF_WR, 32'hFFFF_FFFF, 32'd0, "wrap_c0");
    step(1'b1, OPC_COEF_WR, 32'h8000_0001, 32'd1, "wrap_c1");
    push_read(32'h0001_0003, "wrap_read1");
    push_read(32'hFFFF_FFFE, "wrap_read2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
